// File: rtl/ipsmacge_pkg.sv
// rtl/ipsmacge_pkg.sv - shared constants and types for the multi-port GMII/RGMII/MII transmit interface
package ipsmacge_pkg;

    localparam int DAT_DW = 8;
    localparam int NIB_DW = DAT_DW / 2;
    localparam int MSP_DW = 2;
    localparam int CNT_DW = 16;

    localparam logic [MSP_DW-1:0] M10      = 2'b00;
    localparam logic [MSP_DW-1:0] M100     = 2'b01;
    localparam logic [MSP_DW-1:0] M1000    = 2'b10;
    localparam logic [MSP_DW-1:0] MRESERVE = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_LO   = 2'b01,
        ST_HI   = 2'b10
    } state_t;

endpackage

// File: rtl/ipsmacge_txintf_port.sv
// rtl/ipsmacge_txintf_port.sv - one transmit port: shadow config, nibble FSM, DDIO output registers (IPSMACGE_TXINTF_FRMCNT_EN adds frame counter)
module ipsmacge_txintf_port
    import ipsmacge_pkg::*;
(
    input  logic              txclk,
    input  logic              txrst_,
    input  logic [DAT_DW-1:0] igdat,
    input  logic              igen,
    input  logic              iger,
    output logic              igrdy,
    input  logic              txce,
    output logic [DAT_DW-1:0] txhdat,
    output logic [DAT_DW-1:0] txldat,
    output logic              txhctl,
    output logic              txlctl,
    output logic              txherr,
    output logic              txlerr,
    input  logic              up_act,
    input  logic              up_gmii,
    input  logic [MSP_DW-1:0] up_spd
`ifdef IPSMACGE_TXINTF_FRMCNT_EN
    ,
    input  logic              up_cntclr,
    output logic [CNT_DW-1:0] txfrm_cnt
`endif
);

    logic              sh_gmii;
    logic [MSP_DW-1:0] sh_spd;
    state_t            state, state_nxt;
    logic [DAT_DW-1:0] byte_q, byte_nxt;
    logic              er_q, er_nxt;
    logic [NIB_DW-1:0] nib;
    logic              en, er;
    logic              is_gig, is_slow;

    assign is_gig  = (sh_spd == M1000);
    assign is_slow = (sh_spd == M10) || (sh_spd == M100);

    // Config only moves between frames so a frame never changes mode halfway.
    always_ff @(posedge txclk) begin
        if (!txrst_) begin
            sh_gmii <= 1'b0;
            sh_spd  <= MRESERVE;
        end else if (!up_act || (state == ST_IDLE && !igen)) begin
            sh_gmii <= up_gmii;
            sh_spd  <= up_spd;
        end
    end

    always_ff @(posedge txclk) begin
        if (!txrst_) begin
            state  <= ST_IDLE;
            byte_q <= '0;
            er_q   <= 1'b0;
        end else begin
            state  <= state_nxt;
            byte_q <= byte_nxt;
            er_q   <= er_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        byte_nxt  = byte_q;
        er_nxt    = er_q;
        igrdy     = 1'b0;
        if (up_act && is_gig) begin
            igrdy     = 1'b1;
            state_nxt = ST_IDLE;
        end else if (up_act && is_slow) begin
            unique case (state)
                ST_IDLE: begin
                    igrdy = txce;
                    if (txce && igen) begin
                        byte_nxt  = igdat;
                        er_nxt    = iger;
                        state_nxt = ST_LO;
                    end
                end
                ST_LO: begin
                    if (txce) state_nxt = ST_HI;
                end
                ST_HI: begin
                    igrdy = txce;
                    if (txce && igen) begin
                        byte_nxt  = igdat;
                        er_nxt    = iger;
                        state_nxt = ST_LO;
                    end else if (txce) begin
                        byte_nxt  = '0;
                        er_nxt    = 1'b0;
                        state_nxt = ST_IDLE;
                    end
                end
                default: state_nxt = ST_IDLE;
            endcase
        end else begin
            state_nxt = ST_IDLE;
            byte_nxt  = '0;
            er_nxt    = 1'b0;
        end

        // Slow-mode outputs follow the state being entered on this strobe.
        unique case (state_nxt)
            ST_LO:   nib = byte_nxt[NIB_DW-1:0];
            ST_HI:   nib = byte_nxt[DAT_DW-1:NIB_DW];
            default: nib = '0;
        endcase
        en = (state_nxt != ST_IDLE);
        er = er_nxt & en;
    end

    always_ff @(posedge txclk) begin
        if (!txrst_ || !up_act || !(is_gig || is_slow)) begin
            txhdat <= '0;
            txldat <= '0;
            txhctl <= 1'b0;
            txlctl <= 1'b0;
            txherr <= 1'b0;
            txlerr <= 1'b0;
        end else if (is_gig) begin
            txhctl <= igen;
            if (sh_gmii) begin
                txhdat <= igdat;
                txldat <= igdat;
                txlctl <= igen;
                txherr <= iger;
                txlerr <= iger;
            end else begin
                txhdat <= {{NIB_DW{1'b0}}, igdat[NIB_DW-1:0]};
                txldat <= {{NIB_DW{1'b0}}, igdat[DAT_DW-1:NIB_DW]};
                txlctl <= igen ^ iger;
                txherr <= 1'b0;
                txlerr <= 1'b0;
            end
        end else if (txce) begin
            txhdat <= {{NIB_DW{1'b0}}, nib};
            txldat <= {{NIB_DW{1'b0}}, nib};
            txhctl <= en;
            txlctl <= sh_gmii ? en : (en ^ er);
            txherr <= sh_gmii & er;
            txlerr <= sh_gmii & er;
        end
    end

`ifdef IPSMACGE_TXINTF_FRMCNT_EN
    logic              in_frm;
    logic [CNT_DW-1:0] cnt;
    logic              frm_start;

    assign frm_start = igen && igrdy && !in_frm;

    always_ff @(posedge txclk) begin
        if (!txrst_) begin
            in_frm <= 1'b0;
            cnt    <= '0;
        end else begin
            if (!up_act || !igen)  in_frm <= 1'b0;
            else if (igrdy)        in_frm <= 1'b1;
            if (up_cntclr)         cnt <= '0;
            else if (frm_start)    cnt <= cnt + 1'b1;
        end
    end

    assign txfrm_cnt = cnt;
`endif

endmodule

// File: rtl/ipsmacge_txintf_mp.sv
// rtl/ipsmacge_txintf_mp.sv - NPORT-wide GMII to (R)GMII/MII transmit interface (IPSMACGE_TXINTF_FRMCNT_EN adds frame counters)
module ipsmacge_txintf_mp
    import ipsmacge_pkg::*;
#(
    parameter int NPORT = 4
) (
    input  logic                     txclk,
    input  logic                     txrst_,
    input  logic [NPORT*DAT_DW-1:0]  igdat,
    input  logic [NPORT-1:0]         igen,
    input  logic [NPORT-1:0]         iger,
    output logic [NPORT-1:0]         igrdy,
    input  logic [NPORT-1:0]         txce,
    output logic [NPORT*DAT_DW-1:0]  txhdat,
    output logic [NPORT*DAT_DW-1:0]  txldat,
    output logic [NPORT-1:0]         txhctl,
    output logic [NPORT-1:0]         txlctl,
    output logic [NPORT-1:0]         txherr,
    output logic [NPORT-1:0]         txlerr,
    input  logic [NPORT-1:0]         up_act,
    input  logic [NPORT-1:0]         up_gmii,
    input  logic [NPORT*MSP_DW-1:0]  up_spd
`ifdef IPSMACGE_TXINTF_FRMCNT_EN
    ,
    input  logic [NPORT-1:0]         up_cntclr,
    output logic [NPORT*CNT_DW-1:0]  txfrm_cnt
`endif
);

    for (genvar p = 0; p < NPORT; p++) begin : g_port
        ipsmacge_txintf_port u_port (
            .txclk     (txclk),
            .txrst_    (txrst_),
            .igdat     (igdat[p*DAT_DW +: DAT_DW]),
            .igen      (igen[p]),
            .iger      (iger[p]),
            .igrdy     (igrdy[p]),
            .txce      (txce[p]),
            .txhdat    (txhdat[p*DAT_DW +: DAT_DW]),
            .txldat    (txldat[p*DAT_DW +: DAT_DW]),
            .txhctl    (txhctl[p]),
            .txlctl    (txlctl[p]),
            .txherr    (txherr[p]),
            .txlerr    (txlerr[p]),
            .up_act    (up_act[p]),
            .up_gmii   (up_gmii[p]),
            .up_spd    (up_spd[p*MSP_DW +: MSP_DW])
`ifdef IPSMACGE_TXINTF_FRMCNT_EN
            ,
            .up_cntclr (up_cntclr[p]),
            .txfrm_cnt (txfrm_cnt[p*CNT_DW +: CNT_DW])
`endif
        );
    end

endmodule

// File: tb/tb_ipsmacge_txintf_mp.sv
// tb/tb_ipsmacge_txintf_mp.sv - directed self-checking bench for ipsmacge_txintf_mp
module tb_ipsmacge_txintf_mp;

    logic        txclk = 1'b0;
    logic        txrst_;
    logic [31:0] igdat;
    logic [3:0]  igen, iger, igrdy, txce;
    logic [31:0] txhdat, txldat;
    logic [3:0]  txhctl, txlctl, txherr, txlerr;
    logic [3:0]  up_act, up_gmii;
    logic [7:0]  up_spd;
`ifdef IPSMACGE_TXINTF_FRMCNT_EN
    logic [3:0]  up_cntclr;
    logic [63:0] txfrm_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 txclk = ~txclk;

    ipsmacge_txintf_mp #(.NPORT(4)) dut (
        .txclk     (txclk),
        .txrst_    (txrst_),
        .igdat     (igdat),
        .igen      (igen),
        .iger      (iger),
        .igrdy     (igrdy),
        .txce      (txce),
        .txhdat    (txhdat),
        .txldat    (txldat),
        .txhctl    (txhctl),
        .txlctl    (txlctl),
        .txherr    (txherr),
        .txlerr    (txlerr),
        .up_act    (up_act),
        .up_gmii   (up_gmii),
        .up_spd    (up_spd)
`ifdef IPSMACGE_TXINTF_FRMCNT_EN
        ,
        .up_cntclr (up_cntclr),
        .txfrm_cnt (txfrm_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge txclk);
        #1;
    endtask

    task automatic gap(input int n);
        repeat (n) tick();
    endtask

    // One txce slot on port p; igrdy is checked while the strobe is high.
    task automatic strobe(input int p, input logic exp_rdy, input string tag);
        txce[p] = 1'b1;
        #1;
        chk(tag, 32'(igrdy[p]), 32'(exp_rdy));
        tick();
        txce[p] = 1'b0;
    endtask

    initial begin
        txrst_  = 1'b0;
        igdat   = '0;
        igen    = '0;
        iger    = '0;
        txce    = '0;
        up_act  = 4'b1111;
        up_gmii = 4'b0101;
        up_spd  = {2'b00, 2'b01, 2'b10, 2'b10};
`ifdef IPSMACGE_TXINTF_FRMCNT_EN
        up_cntclr = '0;
`endif
        gap(2);
        chk("rst_hdat", txhdat, 32'h0);
        chk("rst_ldat", txldat, 32'h0);
        chk("rst_ctl", {24'h0, txhctl, txlctl}, 32'h0);
        chk("rst_err", {24'h0, txherr, txlerr}, 32'h0);
        chk("rst_igrdy", 32'(igrdy), 32'h0);
`ifdef IPSMACGE_TXINTF_FRMCNT_EN
        chk("rst_cnt0", 32'(txfrm_cnt[15:0]), 32'h0);
`endif
        txrst_ = 1'b1;
        tick();
        chk("cfg_igrdy", 32'(igrdy), 32'h3);

        // Port0 GMII 1000
        igen[0] = 1'b1;
        igdat[7:0] = 8'h55; tick();
        chk("p0_b0_h", 32'(txhdat[7:0]), 32'h55);
        chk("p0_b0_l", 32'(txldat[7:0]), 32'h55);
        chk("p0_b0_ctl", 32'({txhctl[0], txlctl[0], igrdy[0]}), 32'h7);
        igdat[7:0] = 8'hD5; tick();
        chk("p0_b1_h", 32'(txhdat[7:0]), 32'hD5);
        igdat[7:0] = 8'hA7; tick();
        chk("p0_b2_hl", 32'({txhdat[7:0], txldat[7:0]}), 32'hA7A7);
        chk("p0_b2_rdy", 32'(igrdy[0]), 32'h1);
        igen[0] = 1'b0; tick();
        chk("p0_end_ctl", 32'({txhctl[0], txlctl[0]}), 32'h0);

        // Port1 RGMII 1000 with error
        igdat[15:8] = 8'h3C; igen[1] = 1'b1; iger[1] = 1'b1; tick();
        chk("p1_h", 32'(txhdat[15:8]), 32'h0C);
        chk("p1_l", 32'(txldat[15:8]), 32'h03);
        chk("p1_ctl", 32'({txhctl[1], txlctl[1], txherr[1], txlerr[1]}), 32'h8);
        igen[1] = 1'b0; iger[1] = 1'b0; tick();

        // Port2 MII 100, txce every 4th cycle
        igdat[23:16] = 8'h5A; igen[2] = 1'b1;
        #1 chk("p2_rdy_noce", 32'(igrdy[2]), 32'h0);
        strobe(2, 1'b1, "p2_rdy_idle");
        chk("p2_n0", 32'({txhdat[23:16], txldat[23:16]}), 32'h0A0A);
        chk("p2_n0_ctl", 32'({txhctl[2], txlctl[2], txherr[2]}), 32'h6);
        igdat[23:16] = 8'h81;
        gap(3);
        chk("p2_hold", 32'({txhdat[23:16], 7'h0, igrdy[2]}), 32'h0A00);
        strobe(2, 1'b0, "p2_rdy_lo");
        chk("p2_n1", 32'(txhdat[23:16]), 32'h05);
        gap(3);
        strobe(2, 1'b1, "p2_rdy_hi");
        chk("p2_n2", 32'(txhdat[23:16]), 32'h01);
        igen[2] = 1'b0;
        gap(3);
        strobe(2, 1'b0, "p2_rdy_lo2");
        chk("p2_n3", 32'(txhdat[23:16]), 32'h08);
        gap(3);
        strobe(2, 1'b1, "p2_rdy_hi2");
        chk("p2_idle", 32'({txhdat[23:16], 7'h0, txhctl[2]}), 32'h0);

        // Port3 RGMII 10, speed changed to 1000 mid-frame
        igdat[31:24] = 8'h96; igen[3] = 1'b1; iger[3] = 1'b1;
        strobe(3, 1'b1, "p3_rdy_idle");
        chk("p3_n0", 32'({txhdat[31:24], txldat[31:24]}), 32'h0606);
        chk("p3_n0_ctl", 32'({txhctl[3], txlctl[3], txherr[3], txlerr[3]}), 32'h8);
        up_spd[7:6] = 2'b10; igen[3] = 1'b0; iger[3] = 1'b0;
        gap(3);
        chk("p3_still_slow", 32'(igrdy[3]), 32'h0);
        strobe(3, 1'b0, "p3_rdy_lo");
        chk("p3_n1", 32'({txhdat[31:24], 6'h0, txhctl[3], txlctl[3]}), 32'h0902);
        gap(3);
        strobe(3, 1'b1, "p3_rdy_hi");
        chk("p3_idle", 32'({txhdat[31:24], 7'h0, txhctl[3]}), 32'h0);
        tick();
        chk("p3_gig_rdy", 32'(igrdy[3]), 32'h1);
        igdat[31:24] = 8'h3C; igen[3] = 1'b1; tick();
        chk("p3_gig", 32'({txhdat[31:24], txldat[31:24], 6'h0, txhctl[3], txlctl[3]}), 32'h0C0303);
        igen[3] = 1'b0; tick();

        // Port2 up_act dropped during LO
        igdat[23:16] = 8'hC3; igen[2] = 1'b1;
        strobe(2, 1'b1, "p2a_rdy");
        chk("p2a_n0", 32'(txhdat[23:16]), 32'h03);
        up_act[2] = 1'b0; txce[2] = 1'b1; tick();
        chk("p2a_off", 32'({txhdat[23:16], txldat[23:16], 6'h0, txhctl[2], igrdy[2]}), 32'h0);
        txce[2] = 1'b0; up_act[2] = 1'b1; igen[2] = 1'b0; tick();
        igdat[23:16] = 8'h7E; igen[2] = 1'b1;
        strobe(2, 1'b1, "p2a_resume_rdy");
        chk("p2a_n0b", 32'({txhdat[23:16], 7'h0, txhctl[2]}), 32'h0E01);
        igen[2] = 1'b0; txce[2] = 1'b1; tick();
        chk("p2a_fast_hi", 32'(txhdat[23:16]), 32'h07);
        tick();
        chk("p2a_fast_idle", 32'({txhdat[23:16], 7'h0, txhctl[2]}), 32'h0);
        txce[2] = 1'b0;

        // Synchronous reset mid-frame
        igdat[7:0] = 8'h11; igen[0] = 1'b1; tick();
        chk("p0_pre_rst", 32'(txhdat[7:0]), 32'h11);
        txrst_ = 1'b0; tick();
        chk("mid_rst_dat", txhdat | txldat, 32'h0);
        chk("mid_rst_ctl", {24'h0, txhctl, txlctl}, 32'h0);
        txrst_ = 1'b1; igen[0] = 1'b0; tick();
        chk("post_rst_rdy", 32'(igrdy[0]), 32'h1);

`ifdef IPSMACGE_TXINTF_FRMCNT_EN
        for (int i = 0; i < 3; i++) begin
            igdat[7:0] = 8'(i + 1);
            igen[0] = 1'b1;
            gap(2);
            igen[0] = 1'b0;
            tick();
        end
        chk("cnt_3", 32'(txfrm_cnt[15:0]), 32'h3);
        igen[0] = 1'b1; up_cntclr[0] = 1'b1; tick();
        chk("cnt_clr_start", 32'(txfrm_cnt[15:0]), 32'h0);
        up_cntclr[0] = 1'b0; tick();
        chk("cnt_midframe", 32'(txfrm_cnt[15:0]), 32'h0);
        igen[0] = 1'b0; tick();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
